// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect4 move sequencing logic.
package connect4_pkg;

   localparam int DEF_ROWS = 6;
   localparam int DEF_COLS = 4;

   localparam logic [3:0] COL0_N = 4'b1110;
   localparam logic [3:0] COL1_N = 4'b1101;
   localparam logic [3:0] COL2_N = 4'b1011;
   localparam logic [3:0] COL3_N = 4'b0111;

   localparam logic PLAYER1 = 1'b0;
   localparam logic PLAYER2 = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      VALIDATE,
      UPDATE,
      WAIT_RELEASE,
      DONE
   } state_t;

   function automatic logic col_code_valid(input logic [3:0] code);
      return (code == COL0_N) || (code == COL1_N) || (code == COL2_N) || (code == COL3_N);
   endfunction

   function automatic logic [1:0] col_code_index(input logic [3:0] code);
      logic [1:0] idx;
      case (code)
         COL1_N:  idx = 2'd1;
         COL2_N:  idx = 2'd2;
         COL3_N:  idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for a raw push button followed by a one-cycle rising-edge pulse.
module button_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic pulse
);

   logic sync_p0;
   logic sync_p1;
   logic prev_p2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         // stage boundary: metastability settles between p0 and p1
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
      end
   end

   assign level = sync_p1;
   assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/connect4_move_controller.sv
// Validates each drop request against the column fill level, issues add/board write, alternates turns.
module connect4_move_controller
   import connect4_pkg::*;
#(
   parameter int ROWS   = DEF_ROWS,
   parameter int COLS   = DEF_COLS,
   parameter int MOVE_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              drop_btn,
   input  logic [3:0]        column,
   input  logic              new_game,
   input  logic [3*COLS-1:0] count,
   output logic              add,
   output logic              counter_clear,
   output logic              wr_en,
   output logic [1:0]        wr_col,
   output logic [2:0]        wr_row,
   output logic              wr_player,
   output logic              player,
   output logic              illegal,
   output logic              game_over,
   output logic [MOVE_W-1:0] move_count
);

   localparam logic [MOVE_W-1:0] FULL = MOVE_W'(ROWS * COLS);

   state_t            state_q, state_d;
   logic [1:0]        col_q, col_d;
   logic              drop_level, drop_edge;
   logic [2:0]        sel_fill;
   logic [MOVE_W-1:0] move_inc;

   logic              add_d, wr_en_d, illegal_d, clear_d;
   logic [1:0]        wr_col_d;
   logic [2:0]        wr_row_d;
   logic              wr_player_d, player_d, game_over_d;
   logic [MOVE_W-1:0] move_count_d;

   button_sync_edge u_drop_sync (
      .clk   (clk),
      .reset (reset),
      .btn   (drop_btn),
      .level (drop_level),
      .pulse (drop_edge)
   );

   assign sel_fill = count[3*int'(col_q) +: 3];
   assign move_inc = (move_count == FULL) ? move_count : move_count + 1'b1;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      add_d        = 1'b0;
      wr_en_d      = 1'b0;
      illegal_d    = 1'b0;
      clear_d      = 1'b0;
      wr_col_d     = wr_col;
      wr_row_d     = wr_row;
      wr_player_d  = wr_player;
      player_d     = player;
      move_count_d = move_count;
      game_over_d  = game_over;

      // new_game outranks everything, including a drop edge in the same cycle
      if (new_game) begin
         state_d      = IDLE;
         player_d     = PLAYER1;
         move_count_d = '0;
         game_over_d  = 1'b0;
         clear_d      = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (drop_edge) begin
                  if (col_code_valid(column)) begin
                     col_d   = col_code_index(column);
                     state_d = VALIDATE;
                  end else begin
                     illegal_d = 1'b1;
                     state_d   = WAIT_RELEASE;
                  end
               end
            end
            VALIDATE: begin
               if (sel_fill >= 3'(ROWS)) begin
                  illegal_d = 1'b1;
                  state_d   = WAIT_RELEASE;
               end else begin
                  add_d       = 1'b1;
                  wr_en_d     = 1'b1;
                  wr_col_d    = col_q;
                  wr_row_d    = sel_fill;
                  wr_player_d = player;
                  state_d     = UPDATE;
               end
            end
            UPDATE: begin
               player_d     = ~player;
               move_count_d = move_inc;
               if (move_inc == FULL) begin
                  game_over_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (!drop_level) state_d = IDLE;
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         col_q         <= '0;
         add           <= 1'b0;
         wr_en         <= 1'b0;
         illegal       <= 1'b0;
         counter_clear <= 1'b1;
         wr_col        <= '0;
         wr_row        <= '0;
         wr_player     <= 1'b0;
         player        <= PLAYER1;
         move_count    <= '0;
         game_over     <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         add           <= add_d;
         wr_en         <= wr_en_d;
         illegal       <= illegal_d;
         counter_clear <= clear_d;
         wr_col        <= wr_col_d;
         wr_row        <= wr_row_d;
         wr_player     <= wr_player_d;
         player        <= player_d;
         move_count    <= move_count_d;
         game_over     <= game_over_d;
      end
   end

endmodule

// File: tb/tb_connect4_move_controller.sv
// Bench for connect4_move_controller: a game-level model plus a counter-bank stand-in drive count.
module tb_connect4_move_controller;

   localparam int ROWS   = 6;
   localparam int COLS   = 4;
   localparam int MOVE_W = 5;
   localparam int FULL   = ROWS * COLS;

   logic              clk = 1'b0;
   logic              reset;
   logic              drop_btn;
   logic [3:0]        column;
   logic              new_game;
   logic [11:0]       count;
   logic              add, counter_clear, wr_en, wr_player, player, illegal, game_over;
   logic [1:0]        wr_col;
   logic [2:0]        wr_row;
   logic [MOVE_W-1:0] move_count;

   int n_cmp  = 0;
   int n_fail = 0;

   int fill [4];
   bit m_player;
   int m_moves;
   bit m_over;

   always #5 clk = ~clk;

   assign count = {3'(fill[3]), 3'(fill[2]), 3'(fill[1]), 3'(fill[0])};

   connect4_move_controller #(.ROWS(ROWS), .COLS(COLS), .MOVE_W(MOVE_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .drop_btn      (drop_btn),
      .column        (column),
      .new_game      (new_game),
      .count         (count),
      .add           (add),
      .counter_clear (counter_clear),
      .wr_en         (wr_en),
      .wr_col        (wr_col),
      .wr_row        (wr_row),
      .wr_player     (wr_player),
      .player        (player),
      .illegal       (illegal),
      .game_over     (game_over),
      .move_count    (move_count)
   );

   function automatic int zero_bits(input logic [3:0] code);
      int z = 0;
      for (int b = 0; b < 4; b++) if (code[b] == 1'b0) z++;
      return z;
   endfunction

   function automatic int zero_pos(input logic [3:0] code);
      for (int b = 0; b < 4; b++) if (code[b] == 1'b0) return b;
      return 0;
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < 4; c++) fill[c] = 0;
      m_player = 1'b0;
      m_moves  = 0;
      m_over   = 1'b0;
   endfunction

   // One button press with the model's prediction; hold >= 5 cycles before release.
   task automatic play_move(input logic [3:0] code, input int hold, input string tag);
      int  exp_add, exp_ill, exp_at, col, row_exp;
      bit  legal, p_old;
      int  n_add, n_wr, n_ill, add_at, ill_at, mv_old;
      logic [1:0] c_col;
      logic [2:0] c_row;
      logic       c_pl;
      exp_add = 0; exp_ill = 0; exp_at = -1; legal = 0; col = 0; row_exp = 0;
      n_add = 0; n_wr = 0; n_ill = 0; add_at = -1; ill_at = -1;
      c_col = '0; c_row = '0; c_pl = 1'b0;
      p_old = m_player; mv_old = m_moves;
      if (m_over) begin
         exp_add = 0;
      end else if (zero_bits(code) != 1) begin
         exp_ill = 1; exp_at = 3;
      end else begin
         col = zero_pos(code);
         row_exp = fill[col];
         if (fill[col] >= ROWS) begin
            exp_ill = 1; exp_at = 4;
         end else begin
            exp_add = 1; exp_at = 4; legal = 1;
         end
      end
      @(negedge clk);
      column   = code;
      drop_btn = 1'b1;
      for (int i = 1; i <= hold + 6; i++) begin
         @(negedge clk);
         if (i == 3) column = 4'($urandom);
         if (i == hold) drop_btn = 1'b0;
         if (add) begin
            n_add++;
            if (add_at < 0) begin add_at = i; c_col = wr_col; c_row = wr_row; c_pl = wr_player; end
         end
         if (wr_en) n_wr++;
         if (illegal) begin n_ill++; if (ill_at < 0) ill_at = i; end
         if (i == 4 && legal) fill[col]++;
         if (i == 5 && legal) begin
            n_cmp++;
            if (player !== ~p_old || move_count !== MOVE_W'(mv_old + 1)) begin
               n_fail++;
               $display("FAIL %s E+3 update: player=%0b moves=%0d want player=%0b moves=%0d",
                        tag, player, move_count, ~p_old, mv_old + 1);
            end
         end
      end
      n_cmp++;
      if (n_add !== exp_add || n_wr !== exp_add) begin
         n_fail++;
         $display("FAIL %s add/wr_en count: add=%0d wr_en=%0d want %0d", tag, n_add, n_wr, exp_add);
      end
      n_cmp++;
      if (n_ill !== exp_ill) begin
         n_fail++;
         $display("FAIL %s illegal count: got %0d want %0d", tag, n_ill, exp_ill);
      end
      if (exp_add == 1) begin
         n_cmp++;
         if (add_at !== exp_at || c_col !== 2'(col) || c_row !== 3'(row_exp) || c_pl !== p_old) begin
            n_fail++;
            $display("FAIL %s write: at=%0d col=%0d row=%0d pl=%0b want at=%0d col=%0d row=%0d pl=%0b",
                     tag, add_at, c_col, c_row, c_pl, exp_at, col, row_exp, p_old);
         end
      end
      if (exp_ill == 1) begin
         n_cmp++;
         if (ill_at !== exp_at) begin
            n_fail++;
            $display("FAIL %s illegal timing: got cycle %0d want %0d", tag, ill_at, exp_at);
         end
      end
      if (legal) begin
         m_player = ~m_player;
         m_moves++;
         m_over = (m_moves == FULL);
      end
      n_cmp++;
      if (player !== m_player || move_count !== MOVE_W'(m_moves) || game_over !== m_over) begin
         n_fail++;
         $display("FAIL %s state: player=%0b moves=%0d over=%0b want %0b %0d %0b",
                  tag, player, move_count, game_over, m_player, m_moves, m_over);
      end
   endtask

   task automatic do_new_game(input string tag);
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      model_clear();
      n_cmp++;
      if (counter_clear !== 1'b1 || player !== 1'b0 || move_count !== '0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after new_game: clr=%0b player=%0b moves=%0d over=%0b want 1 0 0 0",
                  tag, counter_clear, player, move_count, game_over);
      end
      @(negedge clk);
      n_cmp++;
      if (counter_clear !== 1'b0) begin
         n_fail++;
         $display("FAIL %s counter_clear width: got %0b want 0", tag, counter_clear);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; drop_btn = 1'b0; column = 4'hF; new_game = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (counter_clear !== 1'b1 || add !== 1'b0 || wr_en !== 1'b0 || illegal !== 1'b0 ||
          player !== 1'b0 || move_count !== '0 || game_over !== 1'b0 ||
          wr_col !== '0 || wr_row !== '0 || wr_player !== 1'b0) begin
         n_fail++;
         $display("FAIL reset values: clr=%0b add=%0b wr=%0b ill=%0b pl=%0b mc=%0d go=%0b wc=%0d wrow=%0d wp=%0b",
                  counter_clear, add, wr_en, illegal, player, move_count, game_over, wr_col, wr_row, wr_player);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (counter_clear !== 1'b0 || add !== 1'b0) begin
         n_fail++;
         $display("FAIL reset release: clr=%0b add=%0b want 0 0", counter_clear, add);
      end
   endtask

   task automatic test_basic();
      play_move(4'b1101, 6, "basic_col1");
   endtask

   task automatic test_hold();
      play_move(4'b1110, 50, "hold_50");
      play_move(4'b1110, 6, "hold_repress");
   endtask

   task automatic test_full_column();
      fill[2] = ROWS;
      play_move(4'b1011, 6, "full_col2");
      fill[2] = 7;
      play_move(4'b1011, 6, "over_full_col2");
      fill[2] = 0;
   endtask

   task automatic test_malformed();
      play_move(4'b1100, 6, "malformed_1100");
      play_move(4'b1111, 6, "malformed_1111");
      play_move(4'b0000, 6, "malformed_0000");
   endtask

   task automatic test_random();
      logic [3:0] codes [4];
      logic [3:0] code;
      codes[0] = 4'b1110; codes[1] = 4'b1101; codes[2] = 4'b1011; codes[3] = 4'b0111;
      do_new_game("rand_start");
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 9) < 8) code = codes[$urandom_range(0, 3)];
         else code = 4'($urandom);
         if ($urandom_range(0, 4) == 0) fill[$urandom_range(0, 3)] = $urandom_range(0, 7);
         play_move(code, $urandom_range(5, 10), "random");
      end
   endtask

   task automatic test_game_over();
      logic [3:0] codes [4];
      codes[0] = 4'b1110; codes[1] = 4'b1101; codes[2] = 4'b1011; codes[3] = 4'b0111;
      do_new_game("go_start");
      for (int k = 0; k < FULL; k++) play_move(codes[k % 4], 5, "fill_board");
      n_cmp++;
      if (game_over !== 1'b1 || move_count !== MOVE_W'(FULL)) begin
         n_fail++;
         $display("FAIL board full: over=%0b moves=%0d want 1 %0d", game_over, move_count, FULL);
      end
      play_move(4'b1110, 6, "press_when_done");
      play_move(4'b1100, 6, "malformed_when_done");
      do_new_game("go_restart");
   endtask

   task automatic test_new_game_race(input int ng_at, input string tag);
      int n_add, n_clr;
      n_add = 0; n_clr = 0;
      @(negedge clk);
      column   = 4'b0111;
      drop_btn = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         new_game = (i == ng_at);
         if (i == 8) drop_btn = 1'b0;
         if (add || wr_en) n_add++;
         if (counter_clear) n_clr++;
      end
      new_game = 1'b0;
      model_clear();
      n_cmp++;
      if (n_add !== 0 || n_clr !== 1) begin
         n_fail++;
         $display("FAIL %s: add/wr pulses=%0d clears=%0d want 0 1", tag, n_add, n_clr);
      end
      n_cmp++;
      if (player !== 1'b0 || move_count !== '0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL %s state: player=%0b moves=%0d over=%0b want 0 0 0",
                  tag, player, move_count, game_over);
      end
      play_move(4'b0111, 6, "after_race");
   endtask

   task automatic test_reset_midmove();
      @(negedge clk);
      column   = 4'b1110;
      drop_btn = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (add !== 1'b1) begin
         n_fail++;
         $display("FAIL midmove add before reset: got %0b want 1", add);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (add !== 1'b0 || wr_en !== 1'b0 || counter_clear !== 1'b1) begin
         n_fail++;
         $display("FAIL midmove async kill: add=%0b wr_en=%0b clr=%0b want 0 0 1", add, wr_en, counter_clear);
      end
      drop_btn = 1'b0;
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (counter_clear !== 1'b0 || player !== 1'b0 || move_count !== '0) begin
         n_fail++;
         $display("FAIL midmove recovery: clr=%0b player=%0b moves=%0d want 0 0 0",
                  counter_clear, player, move_count);
      end
      play_move(4'b1101, 6, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_full_column();
      test_malformed();
      test_random();
      test_game_over();
      test_new_game_race(2, "new_game_with_edge");
      test_new_game_race(3, "new_game_in_validate");
      test_reset_midmove();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
